// File: rtl/shift_pkg.sv
// shift_pkg: select encodings, direction constants and FSM state type shared by
// shift_load_ctrl and its sub-modules.
package shift_pkg;
   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_SHR  = 2'b11;
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      LOAD  = ST_LOAD,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } shift_state_t;
endpackage

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: counts performed shifts and flags the terminal count WIDTH-1;
// it saturates there so it never wraps.
module shift_bit_counter
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic tc
);
   localparam int CW = $clog2(WIDTH);
   logic [CW-1:0] cnt;
   assign tc = cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (en && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/shift_load_ctrl.sv
// shift_load_ctrl: load/shift sequencer driving the shift register's mux select bus.
// Define SHIFT_LOAD_CTRL_ROTATE_EN to feed the departing bit back as the serial fill (rotation).
module shift_load_ctrl
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   output logic [WIDTH-1:0] par_data,
   output logic [1:0]       select,
   output logic             ser_fill,
   input  logic             q_msb,
   input  logic             q_lsb,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_bit,
   output logic             done
);
   shift_state_t state;
   logic dir, tc, shift_go;
   assign in_ready  = state == IDLE;
   assign ser_valid = state == SHIFT;
   assign done      = state == DONE;
   assign ser_bit   = ser_valid & (dir == DIR_RIGHT ? q_lsb : q_msb);
   assign shift_go  = ser_valid & ser_ready;
   // ser_ready reaches select directly so a stall holds the register in the same cycle
   assign select = state == LOAD ? SEL_LOAD :
                   shift_go ? (dir == DIR_RIGHT ? SEL_SHR : SEL_SHL) : SEL_HOLD;
`ifdef SHIFT_LOAD_CTRL_ROTATE_EN
   assign ser_fill = ser_bit;
`else
   assign ser_fill = 1'b0;
`endif
   shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state == LOAD),
      .en    (shift_go),
      .tc    (tc)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         dir      <= DIR_LEFT;
         par_data <= '0;
      end else begin
         case (state)
            IDLE:
               if (in_valid) begin
                  state    <= LOAD;
                  par_data <= in_data;
                  dir      <= in_dir;
               end
            LOAD:    state <= SHIFT;
            SHIFT:   if (shift_go && tc) state <= DONE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_shift_load_ctrl.sv
// tb_shift_load_ctrl: vector table, reset/back-to-back sequences and random words,
// checked against a timeline and serial-stream model with an attached register model.
`timescale 1ns/1ps
module tb_shift_load_ctrl;
   localparam int W = 4;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_dir = 1'b0, ser_ready = 1'b1;
   logic q_msb, q_lsb, in_ready, ser_fill, ser_valid, ser_bit, done;
   logic [W-1:0] in_data = '0, par_data, rg = '0, snap;
   logic [1:0] select;
   int total = 0, bad = 0;

   typedef struct {
      logic [W-1:0] d;
      logic         dr;
      int           sa;
      int           sl;
      logic [W-1:0] es;
   } vec_t;
   vec_t vt[7];

   always #5 clk = ~clk;

   shift_load_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dir(in_dir), .par_data(par_data), .select(select),
      .ser_fill(ser_fill), .q_msb(q_msb), .q_lsb(q_lsb), .ser_valid(ser_valid),
      .ser_ready(ser_ready), .ser_bit(ser_bit), .done(done)
   );

   assign q_msb = rg[W-1];
   assign q_lsb = rg[0];
   always @(posedge clk)
      case (select)
         2'b01:   rg <= par_data;
         2'b10:   rg <= {rg[W-2:0], ser_fill};
         2'b11:   rg <= {ser_fill, rg[W-1:1]};
         default: rg <= rg;
      endcase

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // serial order, first bit at the MSB position of the result
   function automatic logic [W-1:0] stream_of(input logic [W-1:0] d, input logic dr);
      logic [W-1:0] s;
      for (int k = 0; k < W; k++) s[W-1-k] = dr ? d[k] : d[W-1-k];
      return s;
   endfunction

   function automatic logic [W-1:0] end_reg(input logic [W-1:0] d, input int n);
`ifdef SHIFT_LOAD_CTRL_ROTATE_EN
      return W'((d << n) | (d >> (W - n)));
`else
      return W'(d << n);
`endif
   endfunction

   // entered and left at 2ns after an edge with the controller idle
   task automatic run_word(input logic [W-1:0] d, input logic dr, input int sa, input int sl,
                           input logic [W-1:0] es, input logic hold);
      int shifts = 0, stalled = 0, dc;
      logic [W-1:0] got = '0;
      logic [1:0] ssel;
      dc = 2 + W + sl;
      ssel = dr ? 2'b11 : 2'b10;
      chk("ready_before_accept", in_ready, 1);
      in_valid = 1'b1; in_data = d; in_dir = dr; ser_ready = 1'b1;
      for (int c = 1; c <= dc + 1; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin in_valid = hold; in_data = ~d; in_dir = ~dr; end
         ser_ready = !(shifts == sa && stalled < sl);
         #1;
         chk("in_ready", in_ready, c > dc);
         chk("done", done, c == dc);
         if (c <= dc) chk("par_data", par_data, d);
         if (c == 1) chk("sel_load", select, 2'b01);
         else if (c < dc) begin
            chk("ser_valid", ser_valid, 1);
            if (shifts < W) chk("ser_bit", ser_bit, es[W-1-shifts]);
            chk("sel_shift", select, ser_ready ? ssel : 2'b00);
            if (ser_ready) begin
               if (shifts < W) got[W-1-shifts] = ser_bit;
               shifts++;
            end else stalled++;
         end else begin
            chk("sel_idle", select, 2'b00);
            chk("ser_valid_idle", ser_valid, 0);
         end
      end
      chk("stream", got, es);
      chk("shift_count", shifts, W);
      chk("reg_final", rg, end_reg(d, W));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      vt[0] = '{4'b1011, 1'b0, 0, 0, 4'b1011};
      vt[1] = '{4'b1011, 1'b1, 0, 0, 4'b1101};
      vt[2] = '{4'b1011, 1'b0, 2, 3, 4'b1011};
      vt[3] = '{4'b1001, 1'b0, 0, 0, 4'b1001};
      vt[4] = '{4'b0110, 1'b1, 1, 0, 4'b0110};
      vt[5] = '{4'b1110, 1'b1, 0, 1, 4'b0111};
      vt[6] = '{4'b0001, 1'b0, 3, 2, 4'b0001};
      @(posedge clk);
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_select", select, 2'b00);
      chk("rst_par_data", par_data, 0);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_ser_bit", ser_bit, 0);
      chk("rst_ser_fill", ser_fill, 0);
      chk("rst_done", done, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #2;
      for (int i = 0; i < 7; i++) run_word(vt[i].d, vt[i].dr, vt[i].sa, vt[i].sl, vt[i].es, 1'b0);
      // in_valid held high across two words
      run_word(4'b1011, 1'b0, 0, 0, 4'b1011, 1'b1);
      run_word(4'b0110, 1'b1, 0, 0, 4'b0110, 1'b1);
      in_valid = 1'b0;
      // reset asserted after two shifts
      in_valid = 1'b1; in_data = 4'b1011; in_dir = 1'b0; ser_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      snap = rg;
      #1;
      chk("midrst_select", select, 2'b00);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_ser_valid", ser_valid, 0);
      chk("midrst_par_data", par_data, 0);
      chk("midrst_two_shifts", snap, end_reg(4'b1011, 2));
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #2;
         chk("post_rst_select", select, 2'b00);
         chk("post_rst_reg", rg, snap);
      end
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] d;
         logic dr;
         d = W'($urandom_range(0, 2**W - 1));
         dr = 1'($urandom_range(0, 1));
         run_word(d, dr, int'($urandom_range(0, W - 1)), int'($urandom_range(0, 3)), stream_of(d, dr), 1'b0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/shift_load_ctrl.md
# shift_load_ctrl

Sequencer directly upstream of the 4:1 per-bit input multiplexers of the parallel-load shift register. It accepts a parallel word over a valid/ready handshake and drives the shared `select[1:0]` bus: one load cycle, then WIDTH shift cycles in the requested direction, stalling on serial back-pressure. It emits the departing bit of each shift as a serial stream, then signals completion.

## Interface
Parameters:
- `WIDTH`, 4, register width and number of shifts per word (≥2).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  parallel word offered.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  WIDTH  parallel word.
- `in_dir`  in  1  0 = shift left (Q0 ← serial fill), 1 = shift right (Q0 ← Q1); sampled with `in_data`.
- `par_data`  out  WIDTH  drives the mux parallel inputs (Input[i]).
- `select`  out  2  mux select: 00 hold, 01 load, 10 shift left, 11 shift right.
- `ser_fill`  out  1  serial input bit to the register (Ir / left-end input).
- `q_msb`, `q_lsb`  in  1  register end bits fed back from the datapath.
- `ser_valid`  out  1  `ser_bit` is valid this cycle.
- `ser_ready`  in  1  serial consumer accepts `ser_bit`.
- `ser_bit`  out  1  departing bit.
- `done`  out  1  one-cycle pulse after the final shift.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: `in_ready`=1, `select`=00. On `in_valid`&&`in_ready`, capture `in_data` into `par_data` and `in_dir` into the direction register → LOAD.
- LOAD: `select`=01 for exactly one cycle, `in_ready`=0 → SHIFT; shift counter cleared to 0.
- SHIFT: `ser_valid`=1. `ser_bit` = `q_msb` if left, `q_lsb` if right.
  - With `ser_ready`=1: `select`=10 (left) or 11 (right); counter increments.
  - With `ser_ready`=0: `select`=00, counter holds.
  - When the counter reaches WIDTH−1 and `ser_ready`=1 → DONE.
- DONE: `select`=00, `done`=1 for one cycle → IDLE.
- `ser_fill` = 0 in all states (see Configuration).
- `par_data` holds its captured value until the next accept.
- `in_dir` is ignored outside the accept cycle. A direction change mid-word is impossible.
- Counter width is $clog2(WIDTH). It never wraps past WIDTH−1.
- Reset values: state IDLE, `in_ready`=1, `select`=00, `par_data`=0, direction 0, counter 0, `ser_valid`=0, `ser_bit`=0, `ser_fill`=0, `done`=0.
- Reset asserted mid-word aborts immediately: `select` forces to 00 and no further shifts occur.

## Timing
- `select`, `in_ready`, `ser_valid` and `done` are decoded from registered state only. No combinational path from `in_valid` or `ser_ready` to `in_ready`.
- Exception: `select` in SHIFT depends combinationally on `ser_ready`, so the hold takes effect in the same cycle.
- Accept at edge T:
  - LOAD occupies cycle T+1.
  - The first shift occupies T+2.
  - With no stalls, the last shift occupies T+1+WIDTH.
  - `done` occurs at T+2+WIDTH.
  - `in_ready` returns at T+3+WIDTH.
- Throughput with no stalls: one word per WIDTH+3 cycles.
- `ser_bit` is combinational from `q_msb`/`q_lsb`. Each accepted serial bit corresponds to the register state before that edge's shift.

## Configuration
- `SHIFT_LOAD_CTRL_ROTATE_EN` defined: in SHIFT, `ser_fill` = `q_msb` for left shifts and `q_lsb` for right shifts. After WIDTH shifts the register holds the original word (rotation).
- Macro undefined: `ser_fill` is constant 0 and the register ends all-zero.
- Serial output behaviour is identical in both builds.

## Structure
- Package `shift_pkg`:
  - select encodings `SEL_HOLD`=2'b00, `SEL_LOAD`=2'b01, `SEL_SHL`=2'b10, `SEL_SHR`=2'b11.
  - state enum `shift_state_t`.
  - direction constants `DIR_LEFT`=0, `DIR_RIGHT`=1.
- Sub-module `shift_bit_counter`: clear, enable and terminal-count flag at WIDTH−1, with asynchronous active-low reset.
- The FSM and output decode stay in the top module.

## Test plan
- Reset mid-SHIFT (after 2 shifts): `select`=00 and `in_ready`=1 immediately; no shifts follow after release.
- WIDTH=4, accept 4'b1011 with `in_dir`=0, `ser_ready`=1, register model attached → `select` sequence 01,10,10,10,10,00; `ser_bit` stream 1,0,1,1; `done` at T+6.
- Same word with `in_dir`=1 → `select` 01,11,11,11,11; `ser_bit` stream 1,1,0,1.
- `ser_ready` low for 3 cycles after the second shift → `select`=00 during the stall, `ser_valid` held and `ser_bit` stable; total of exactly 4 shifts, `done` delayed by 3 cycles.
- `in_valid` held high continuously → second word accepted only when `in_ready` is high again, once per 7 cycles; `par_data` unchanged during LOAD/SHIFT/DONE.
- With `SHIFT_LOAD_CTRL_ROTATE_EN`, load 4'b1001 and shift left → register returns to 4'b1001. Without the macro, the register ends at 4'b0000.
